// File: rtl/inst_axi_fetch_pkg.sv
// rtl/inst_axi_fetch_pkg.sv - shared FSM encodings, AXI constants and KSEG masks for the fetch master
package inst_axi_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_AR      = 2'd1,
    S_R       = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // kseg0/kseg1 share top bits 2'b10; stripping the top three bits yields the physical address
  localparam logic [31:0] KSEG_SEL_MASK  = 32'hC000_0000;
  localparam logic [31:0] KSEG_SEL_VAL   = 32'h8000_0000;
  localparam logic [31:0] KSEG_PHYS_MASK = 32'h1FFF_FFFF;

endpackage

// File: rtl/inst_addr_map.sv
// rtl/inst_addr_map.sv - combinational kseg0/kseg1 virtual to physical address mapping
module inst_addr_map
  import inst_axi_fetch_pkg::*;
#(
  parameter int MAP_KSEG = 1
) (
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);

  logic in_kseg;

  assign in_kseg = (MAP_KSEG != 0) && ((vaddr & KSEG_SEL_MASK) == KSEG_SEL_VAL);
  assign paddr   = in_kseg ? (vaddr & KSEG_PHYS_MASK) : vaddr;

endmodule

// File: rtl/inst_axi_fetch.sv
// rtl/inst_axi_fetch.sv - single-outstanding AXI4 instruction-fetch master with flush-safe draining
module inst_axi_fetch
  import inst_axi_fetch_pkg::*;
#(
  parameter logic [3:0] ARID_VAL = 4'b0000,
  parameter int         MAP_KSEG = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_req,
  input  logic        flush,
  output logic        valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        inst_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  state_t      state, state_nx;
  logic        pend, pend_nx;
  logic        discard, discard_nx;
  logic        issue, deliver;
  logic [31:0] req_pc;
  logic [31:0] map_addr;
  logic        unused_axi;

  assign unused_axi = ^{rid, rlast};

  inst_addr_map #(.MAP_KSEG(MAP_KSEG)) u_addr_map (
    .vaddr(pc),
    .paddr(map_addr)
  );

  assign arid    = ARID_VAL;
  assign arlen   = 8'd0;
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = (state == S_AR);
  assign rready  = (state == S_R) || (state == S_DISCARD);

  always_comb begin
    state_nx   = state;
    pend_nx    = pend;
    discard_nx = discard;
    issue      = 1'b0;
    deliver    = 1'b0;
    // a redirect or a request we cannot serve yet is remembered once and replayed from IDLE
    if (flush || (pc_req && state != S_IDLE)) pend_nx = 1'b1;
    case (state)
      S_IDLE: begin
        if ((pc_req || pend) && !flush) begin
          issue    = 1'b1;
          pend_nx  = 1'b0;
          state_nx = S_AR;
        end
      end
      S_AR: begin
        if (flush) discard_nx = 1'b1;
        if (arready) state_nx = (discard || flush) ? S_DISCARD : S_R;
      end
      S_R: begin
        if (rvalid) begin
          deliver  = !flush;
          state_nx = S_IDLE;
        end else if (flush) begin
          state_nx = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (rvalid) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (state_nx == S_IDLE) discard_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      pend     <= 1'b0;
      discard  <= 1'b0;
      araddr   <= 32'h0;
      req_pc   <= 32'h0;
      valid    <= 1'b0;
      if_pc    <= 32'h0;
      if_inst  <= 32'h0;
      inst_err <= 1'b0;
    end else begin
      state   <= state_nx;
      pend    <= pend_nx;
      discard <= discard_nx;
      valid   <= deliver;
      if (issue) begin
        araddr <= map_addr;
        req_pc <= pc;
      end
      if (deliver) begin
        if_pc    <= req_pc;
        if_inst  <= (rresp == RESP_OKAY) ? rdata : 32'h0;
        inst_err <= (rresp != RESP_OKAY);
      end
    end
  end

endmodule

// File: doc/inst_axi_fetch.md
Name: inst_axi_fetch

Overview:
- Instruction-fetch master on the AXI4 read channels; the fetch-side producer of the IF/ID stage's valid/if_pc/if_inst.
- Accepts a fetch request (IF/ID next_pc_valid) plus the current PC, issues one single-beat AXI read, and returns the instruction word with a one-cycle valid pulse.
- One outstanding transaction; flush-safe draining of in-flight reads.

Parameters:
- ARID_VAL, 4'b0000, constant arid driven on every request.
- MAP_KSEG, 1, when 1, PCs in 0x8000_0000..0xBFFF_FFFF map to araddr = {3'b000, pc[28:0]}; all other PCs pass through unchanged.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- pc  in  32  PC from pc_reg, sampled when a request is issued
- pc_req  in  1  fetch request (IF/ID next_pc_valid)
- flush  in  1  exception/ERET flush
- valid  out  1  one-cycle pulse: if_pc/if_inst hold a new fetched word
- if_pc  out  32  PC of the returned word
- if_inst  out  32  returned instruction; 0 on error response
- inst_err  out  1  set with valid when rresp != OKAY
- arid  out  4  = ARID_VAL
- araddr  out  32  mapped address
- arlen  out  8  constant 0
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01
- arlock  out  2  constant 0
- arcache  out  4  constant 0
- arprot  out  3  constant 0
- arvalid  out  1  read-address valid
- arready  in  1  read-address ready
- rid  in  4  ignored
- rdata  in  32  read data
- rresp  in  2  read response
- rlast  in  1  ignored (single beat)
- rvalid  in  1  read-data valid
- rready  out  1  read-data ready

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - valid, inst_err, arvalid and rready are 0.
  - araddr, if_pc and if_inst are 0x0000_0000.
  - pend is 0 and discard is 0.
- State machine (states registered): IDLE, AR, R, DISCARD.
- IDLE:
  - If (pc_req | pend) && !flush: latch araddr = map(pc), latch req_pc = pc, clear pend, go to AR.
  - If flush is asserted, stay in IDLE and set pend=1.
- AR:
  - arvalid=1.
  - araddr and arvalid are held stable until arready. arvalid is never withdrawn, even on flush.
  - On arready: go to R, or to DISCARD if a flush was seen during AR (sticky discard flag).
- R:
  - rready=1.
  - On rvalid && !flush, at the next edge:
    - valid=1 for exactly one cycle.
    - if_pc = req_pc.
    - if_inst = (rresp==2'b00) ? rdata : 0.
    - inst_err = (rresp!=0).
    - Go to IDLE.
  - On rvalid && flush: drop the data, no valid pulse, go to IDLE.
  - On flush without rvalid: go to DISCARD.
- DISCARD:
  - rready=1.
  - On rvalid: drop the data, go to IDLE.
- Flush in any state sets pend=1, so the redirected PC is fetched automatically after the drain. The discard flag clears on entering IDLE.
- pc_req while not in IDLE sets pend=1. It is not queued twice.
- Latency, no backpressure: request at edge t → arvalid high in cycle t+1; with arready in t+1, rready in t+2; with rvalid in t+2, valid high in t+3. Minimum request-to-valid is 3 cycles.
- valid is 0 in every cycle other than the single pulse. if_pc and if_inst hold their value between pulses.
- When reset is asserted mid-transaction, outstanding AXI beats are abandoned. The interconnect is reset on the same rst.

Decomposition:
- Shared defines file:
  - FSM state encodings (2-bit).
  - AXI constants: SIZE_4B, BURST_INCR, RESP_OKAY.
  - The KSEG mapping masks.
- Sub-module: one natural one, inst_addr_map (combinational kseg0/kseg1 to physical mapping), reused later by the data-side AXI master.

Test Plan:
- Basic fetch:
  - Stimulus: pc=0xBFC0_0000, pc_req pulse; arready in cycle 1; rvalid in cycle 2 with rdata=0x2408_0001, rresp=0.
  - Required: araddr=0x1FC0_0000; valid in cycle 3 with if_pc=0xBFC0_0000, if_inst=0x2408_0001, inst_err=0.
- AR backpressure:
  - Stimulus: arready held low for 4 cycles.
  - Required: arvalid stays 1 and araddr stays constant for all 4 cycles; exactly one valid pulse after rvalid.
- Flush during AR:
  - Stimulus: flush in cycle 2 while arready is low; arready in cycle 4; rvalid in cycle 5 with rdata=0xDEAD_BEEF; pc changed to 0xBFC0_0380.
  - Required: no valid pulse for 0xDEAD_BEEF; a new AR follows with araddr=0x1FC0_0380.
- Flush coincident with rvalid in R:
  - Required: data dropped, no valid pulse, FSM returns to IDLE and reissues due to pend.
- Error response:
  - Stimulus: rresp=2'b10, rdata=0x1234_5678.
  - Required: valid=1, if_inst=0, inst_err=1.
- Async reset mid-R:
  - Stimulus: rst=0 for 1 cycle with no clk edge.
  - Required: arvalid, rready and valid go to 0 immediately; state is IDLE; if_pc=0.
